// File: rtl/router_pkg.sv
// Shared types and constants for the router packet source: FSM states,
// length/address types and the legality rule for host commands.
package router_pkg;

  localparam int MAX_LEN_DEF = 63;
  localparam int LEN_W       = 6;
  localparam int BUF_DEPTH   = 64;
  localparam int ADDR_MAX    = 2;

  typedef logic [1:0]       addr_t;
  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_DONE
  } state_e;

  function automatic logic cmd_legal(input addr_t addr, input len_t len, input int max_len);
    return (len != '0) && (int'(addr) <= ADDR_MAX) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload store: 64x8 register file, one synchronous write port and one
// asynchronous read port.
module router_pkt_buf
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [7:0] wdata,
  input  logic [5:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [BUF_DEPTH];

  // NOTE: the array has no reset; every byte is written before it is read,
  // and resetting 512 flops would only cost area and reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_pkt_src.sv
// Packet source for a byte-wide router: buffers a host payload, then streams
// header, payload and parity bytes, honouring the router's busy stall.
module router_pkt_src
  import router_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_addr,
  input  logic [5:0]  cmd_len,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic [7:0]  pl_data,
  output logic [7:0]  data_in,
  output logic        pkt_valid,
  input  logic        busy,
  input  logic        err,
  output logic        cmd_rej,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [15:0] pkt_cnt
);

  state_e      state_q, state_d;
  addr_t       addr_q, addr_d;
  len_t        len_q, len_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  par_q, par_d;
  logic        flag_q, flag_d;
  logic        done_cnt_q, done_cnt_d;
  logic        cmd_rej_q, cmd_rej_d;
  logic        pkt_done_q, pkt_done_d;
  logic        pkt_err_q, pkt_err_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  logic       buf_we;
  logic [7:0] buf_rdata;
  logic [7:0] header;
  logic [5:0] last_idx;

  assign header   = {len_q, addr_q};
  assign last_idx = len_q - 6'd1;

  router_pkt_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (pl_data),
    .raddr (idx_q),
    .rdata (buf_rdata)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; reset is synchronous, so it lives inside the clocked block.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      par_q      <= '0;
      flag_q     <= 1'b0;
      done_cnt_q <= 1'b0;
      cmd_rej_q  <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      flag_q     <= flag_d;
      done_cnt_q <= done_cnt_d;
      cmd_rej_q  <= cmd_rej_d;
      pkt_done_q <= pkt_done_d;
      pkt_err_q  <= pkt_err_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    par_d      = par_q;
    flag_d     = flag_q;
    done_cnt_d = done_cnt_q;
    cmd_rej_d  = 1'b0;
    pkt_done_d = 1'b0;
    pkt_err_d  = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    buf_we     = 1'b0;
    cmd_ready  = 1'b0;
    pl_ready   = 1'b0;
    data_in    = 8'h00;
    pkt_valid  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_legal(cmd_addr, cmd_len, MAX_LEN)) begin
            addr_d  = cmd_addr;
            len_d   = cmd_len;
            idx_d   = '0;
            par_d   = '0;
            flag_d  = 1'b0;
            state_d = ST_LOAD;
          end else begin
            cmd_rej_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        pl_ready = 1'b1;
        if (pl_valid) begin
          buf_we = 1'b1;
          par_d  = par_q ^ pl_data;
          if (idx_q == last_idx) begin
            // Fold the header in once, on the way out, so parity covers it too.
            par_d   = par_q ^ pl_data ^ header;
            idx_d   = '0;
            state_d = ST_HEADER;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_HEADER: begin
        data_in   = header;
        pkt_valid = 1'b1;
        if (!busy) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        data_in   = buf_rdata;
        pkt_valid = 1'b1;
        if (!busy) begin
          if (idx_q == last_idx) state_d = ST_PARITY;
          else                   idx_d   = idx_q + 6'd1;
        end
      end
      ST_PARITY: begin
        data_in = par_q;
        if (!busy) begin
          done_cnt_d = 1'b0;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        flag_d = flag_q | err;
        if (done_cnt_q) begin
          pkt_done_d = 1'b1;
          pkt_err_d  = flag_q | err;
          pkt_cnt_d  = pkt_cnt_q + 16'd1;
          state_d    = ST_IDLE;
        end else begin
          done_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_rej  = cmd_rej_q;
  assign pkt_done = pkt_done_q;
  assign pkt_err  = pkt_err_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src: expected router bytes are queued as the
// host side is driven and popped as the block streams them out.
module tb_router_pkt_src;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_addr = '0;
  logic [5:0]  cmd_len = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [7:0]  pl_data = '0;
  logic [7:0]  data_in;
  logic        pkt_valid;
  logic        busy = 1'b0;
  logic        err = 1'b0;
  logic        cmd_rej;
  logic        pkt_done;
  logic        pkt_err;
  logic [15:0] pkt_cnt;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;
  logic [7:0]  pl_bytes [64];

  always #5 clk = ~clk;

  router_pkt_src #(.MAX_LEN(63)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .data_in   (data_in),
    .pkt_valid (pkt_valid),
    .busy      (busy),
    .err       (err),
    .cmd_rej   (cmd_rej),
    .pkt_done  (pkt_done),
    .pkt_err   (pkt_err),
    .pkt_cnt   (pkt_cnt)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command, load the payload from pl_bytes and queue the expected stream.
  task automatic load_pkt(input logic [1:0] a, input logic [5:0] l);
    logic [7:0] hdr;
    logic [7:0] par;
    exp_t       e;
    hdr       = {l, a};
    par       = hdr;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    pl_valid  = 1'b1;
    pl_data   = 8'hEE;
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_pl_ready", pl_ready, 0);
    tick();
    cmd_valid = 1'b0;
    e.data = hdr; e.valid = 1'b1;
    exp_q.push_back(e);
    for (int i = 0; i < int'(l); i++) begin
      check("load_pl_ready", pl_ready, 1);
      if (i == 0) begin
        check("load_cmd_ready", cmd_ready, 0);
        check("load_data_in", data_in, 8'h00);
        check("load_pkt_valid", pkt_valid, 0);
      end
      pl_valid = 1'b1;
      pl_data  = pl_bytes[i];
      par      = par ^ pl_bytes[i];
      e.data = pl_bytes[i]; e.valid = 1'b1;
      exp_q.push_back(e);
      tick();
    end
    pl_valid = 1'b0;
    e.data = par; e.valid = 1'b0;
    exp_q.push_back(e);
  endtask

  // Consume n router bytes, optionally stalling with busy on byte stall_at.
  task automatic drain(input int n, input int stall_at, input int stall_n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL scoreboard_empty observed=%0d expected=nonzero", exp_q.size());
      end
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      check($sformatf("data_in[%0d]", k), data_in, e.data);
      check($sformatf("pkt_valid[%0d]", k), pkt_valid, e.valid);
      if (k == stall_at) begin
        busy = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check($sformatf("stall_data[%0d]", s), data_in, e.data);
          check($sformatf("stall_valid[%0d]", s), pkt_valid, e.valid);
        end
        busy = 1'b0;
      end
      tick();
    end
  endtask

  task automatic finish_pkt(input logic err1, input logic exp_err);
    check("done1_data_in", data_in, 8'h00);
    check("done1_pkt_valid", pkt_valid, 0);
    check("done1_pkt_done", pkt_done, 0);
    check("done1_cmd_ready", cmd_ready, 0);
    err = err1;
    tick();
    err = 1'b0;
    check("done2_pkt_done", pkt_done, 0);
    check("done2_data_in", data_in, 8'h00);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check("pkt_done_pulse", pkt_done, 1);
    check("pkt_err", pkt_err, exp_err);
    check("pkt_cnt", pkt_cnt, exp_cnt);
    check("post_cmd_ready", cmd_ready, 1);
    tick();
    check("pkt_done_clear", pkt_done, 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic reject(input logic [1:0] a, input logic [5:0] l);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    check("rej_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("rej_pulse", cmd_rej, 1);
    check("rej_cmd_ready_after", cmd_ready, 1);
    check("rej_pkt_valid", pkt_valid, 0);
    check("rej_data_in", data_in, 8'h00);
    check("rej_pl_ready", pl_ready, 0);
    tick();
    check("rej_pulse_end", cmd_rej, 0);
    check("rej_pkt_cnt", pkt_cnt, exp_cnt);
    check("rej_no_done", pkt_done, 0);
    check("rej_still_idle", pkt_valid, 0);
  endtask

  initial begin
    resetn = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_pl_ready", pl_ready, 0);
    check("rst_data_in", data_in, 8'h00);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_cmd_rej", cmd_rej, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_pkt_cnt", pkt_cnt, 16'h0000);
    resetn = 1'b1;
    tick();

    // Basic three-byte packet to port 1, router never busy.
    pl_bytes[0] = 8'hA1; pl_bytes[1] = 8'hB2; pl_bytes[2] = 8'hC3;
    load_pkt(2'd1, 6'd3);
    drain(5, -1, 0);
    finish_pkt(1'b0, 1'b0);

    // Same packet, router busy for 3 cycles while 0xB2 is presented.
    load_pkt(2'd1, 6'd3);
    drain(5, 2, 3);
    finish_pkt(1'b0, 1'b0);

    // Illegal commands.
    reject(2'd3, 6'd5);
    reject(2'd0, 6'd0);

    // Maximum length to port 2, err raised in the first DONE cycle.
    for (int i = 0; i < 63; i++) pl_bytes[i] = 8'($urandom_range(0, 255));
    load_pkt(2'd2, 6'd63);
    drain(65, 10, 2);
    finish_pkt(1'b1, 1'b1);

    // Reset in the middle of the payload: packet discarded.
    pl_bytes[0] = 8'hA1; pl_bytes[1] = 8'hB2; pl_bytes[2] = 8'hC3;
    load_pkt(2'd1, 6'd3);
    drain(2, -1, 0);
    check("mid_payload_valid", pkt_valid, 1);
    resetn = 1'b0;
    tick();
    exp_q.delete();
    exp_cnt = '0;
    check("abort_pkt_valid", pkt_valid, 0);
    check("abort_data_in", data_in, 8'h00);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_pl_ready", pl_ready, 0);
    check("abort_pkt_done", pkt_done, 0);
    check("abort_pkt_cnt", pkt_cnt, exp_cnt);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_done", pkt_done, 0);
      check("abort_idle_valid", pkt_valid, 0);
    end

    // A clean packet after the abort restarts the count from zero.
    pl_bytes[0] = 8'h5A;
    load_pkt(2'd0, 6'd1);
    drain(3, 0, 1);
    finish_pkt(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
